// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: command encoding, FSM states,
// captured-flag bundle and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic carryout;
        logic zero;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_settle_timer.sv
// Loadable down-counter; done_o flags the enabled cycle in which the count is 0.
module alu_settle_timer #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 en_i,
    output logic                 done_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one operation to the combinational ALU, waits a fixed settle window,
// captures result and flags, and holds them on a valid/ready response port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_WIDTH     = 4,
    parameter int TXN_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [2:0]           req_cmd,
    output logic [WIDTH-1:0]     alu_operand_a,
    output logic [WIDTH-1:0]     alu_operand_b,
    output logic [2:0]           alu_command,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_carryout,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_carryout,
    output logic                 rsp_zero,
    output logic                 rsp_overflow,
    output logic [2:0]           rsp_cmd,
    output logic                 busy,
    output logic [TXN_WIDTH-1:0] txn_count
);

    alu_state_e           state_q, state_d;
    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    alu_cmd_e             cmd_q, cmd_d, rcmd_q, rcmd_d;
    alu_flags_t           flg_q, flg_d;
    logic [TXN_WIDTH-1:0] txn_q, txn_d;
    logic                 accept, capture, rsp_done, timer_done;

    alu_settle_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (CNT_WIDTH'(SETTLE_CYCLES - 1)),
        .en_i       (state_q == SETTLE),
        .done_o     (timer_done)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                accept  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: if (timer_done) begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU drive only moves on accept so the gate-level ALU sees no glitches in IDLE.
    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        cmd_d  = cmd_q;
        rcmd_d = rcmd_q;
        res_d  = res_q;
        flg_d  = flg_q;
        txn_d  = txn_q;
        if (accept) begin
            opa_d  = req_a;
            opb_d  = req_b;
            cmd_d  = alu_cmd_e'(req_cmd);
            rcmd_d = alu_cmd_e'(req_cmd);
        end
        if (capture) begin
            res_d = alu_result;
            flg_d = '{carryout: alu_carryout, zero: alu_zero, overflow: alu_overflow};
        end
        if (rsp_done)
            txn_d = txn_q + TXN_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= ALU_ADD;
            rcmd_q  <= ALU_ADD;
            res_q   <= '0;
            flg_q   <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cmd_q   <= cmd_d;
            rcmd_q  <= rcmd_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            txn_q   <= txn_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign busy          = (state_q != IDLE);
    assign alu_operand_a = opa_q;
    assign alu_operand_b = opb_q;
    assign alu_command   = cmd_q;
    assign rsp_result    = res_q;
    assign rsp_carryout  = flg_q.carryout;
    assign rsp_zero      = flg_q.zero;
    assign rsp_overflow  = flg_q.overflow;
    assign rsp_cmd       = rcmd_q;
    assign txn_count     = txn_q;

endmodule
